// File: rtl/taxi_pcie_vpd_apb_arb.sv
// Purpose: shares one VPD store APB port between the VPD capability (port 0) and a management master (port 1).
// Latency: 4 cycles per zero-wait transfer (IDLE, SETUP, ACCESS, DONE), plus 1 cycle per store wait state.
// Backpressure: the losing requester holds psel until granted; a hung store is aborted after TIMEOUT ACCESS cycles.
module taxi_pcie_vpd_apb_arb #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 1024,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int STRB_W      = DATA_W / 8,
  parameter int AUSER_W     = 1,
  parameter int WUSER_W     = 1
) (
  input  logic               clk,
  input  logic               rst,
  // port 0 (VPD capability)
  input  logic [ADDR_W-1:0]  s0_apb_paddr,
  input  logic [2:0]         s0_apb_pprot,
  input  logic               s0_apb_psel,
  input  logic               s0_apb_penable,
  input  logic               s0_apb_pwrite,
  input  logic [DATA_W-1:0]  s0_apb_pwdata,
  input  logic [STRB_W-1:0]  s0_apb_pstrb,
  input  logic [AUSER_W-1:0] s0_apb_pauser,
  input  logic [WUSER_W-1:0] s0_apb_pwuser,
  output logic               s0_apb_pready,
  output logic [DATA_W-1:0]  s0_apb_prdata,
  output logic               s0_apb_pslverr,
  // port 1 (management)
  input  logic [ADDR_W-1:0]  s1_apb_paddr,
  input  logic [2:0]         s1_apb_pprot,
  input  logic               s1_apb_psel,
  input  logic               s1_apb_penable,
  input  logic               s1_apb_pwrite,
  input  logic [DATA_W-1:0]  s1_apb_pwdata,
  input  logic [STRB_W-1:0]  s1_apb_pstrb,
  input  logic [AUSER_W-1:0] s1_apb_pauser,
  input  logic [WUSER_W-1:0] s1_apb_pwuser,
  output logic               s1_apb_pready,
  output logic [DATA_W-1:0]  s1_apb_prdata,
  output logic               s1_apb_pslverr,
  // downstream VPD store
  output logic [ADDR_W-1:0]  m_apb_paddr,
  output logic [2:0]         m_apb_pprot,
  output logic               m_apb_psel,
  output logic               m_apb_penable,
  output logic               m_apb_pwrite,
  output logic [DATA_W-1:0]  m_apb_pwdata,
  output logic [STRB_W-1:0]  m_apb_pstrb,
  output logic [AUSER_W-1:0] m_apb_pauser,
  output logic [WUSER_W-1:0] m_apb_pwuser,
  input  logic               m_apb_pready,
  input  logic [DATA_W-1:0]  m_apb_prdata,
  input  logic               m_apb_pslverr,
  output logic               stat_timeout
);

  // Strobe lanes must cover the data bus exactly.
  if (STRB_W * 8 != DATA_W) begin : g_bad_strb
    $fatal(1, "taxi_pcie_vpd_apb_arb: STRB_W must equal DATA_W/8");
  end

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   m_paddr_q, m_paddr_d;
  logic [2:0]          m_pprot_q, m_pprot_d;
  logic                m_psel_q, m_psel_d;
  logic                m_penable_q, m_penable_d;
  logic                m_pwrite_q, m_pwrite_d;
  logic [DATA_W-1:0]   m_pwdata_q, m_pwdata_d;
  logic [STRB_W-1:0]   m_pstrb_q, m_pstrb_d;
  logic [AUSER_W-1:0]  m_pauser_q, m_pauser_d;
  logic [WUSER_W-1:0]  m_pwuser_q, m_pwuser_d;
  logic                s0_pready_q, s0_pready_d, s1_pready_q, s1_pready_d;
  logic [DATA_W-1:0]   s0_prdata_q, s0_prdata_d, s1_prdata_q, s1_prdata_d;
  logic                s0_pslverr_q, s0_pslverr_d, s1_pslverr_q, s1_pslverr_d;
  logic                stat_timeout_q, stat_timeout_d;
  logic                pick;
  logic                rsp_vld;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  // Requesters assert psel in either phase, so penable carries no arbitration information.
  logic unused_penable;
  assign unused_penable = s0_apb_penable ^ s1_apb_penable;

  // Arbitration, transfer sequencing, timeout and response steering.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    m_paddr_d      = m_paddr_q;
    m_pprot_d      = m_pprot_q;
    m_psel_d       = m_psel_q;
    m_penable_d    = m_penable_q;
    m_pwrite_d     = m_pwrite_q;
    m_pwdata_d     = m_pwdata_q;
    m_pstrb_d      = m_pstrb_q;
    m_pauser_d     = m_pauser_q;
    m_pwuser_d     = m_pwuser_q;
    s0_pready_d    = 1'b0;
    s0_prdata_d    = '0;
    s0_pslverr_d   = 1'b0;
    s1_pready_d    = 1'b0;
    s1_prdata_d    = '0;
    s1_pslverr_d   = 1'b0;
    stat_timeout_d = 1'b0;
    pick           = 1'b0;
    rsp_vld        = 1'b0;
    rsp_rdata      = '0;
    rsp_err        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s0_apb_psel || s1_apb_psel) begin
          // On a tie, round-robin favours the port that was not served last.
          if (s0_apb_psel && s1_apb_psel) begin
            pick = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
          end else begin
            pick = s1_apb_psel;
          end
          gnt_d      = pick;
          last_d     = pick;
          cnt_d      = '0;
          m_paddr_d  = pick ? s1_apb_paddr  : s0_apb_paddr;
          m_pprot_d  = pick ? s1_apb_pprot  : s0_apb_pprot;
          m_pwrite_d = pick ? s1_apb_pwrite : s0_apb_pwrite;
          m_pwdata_d = pick ? s1_apb_pwdata : s0_apb_pwdata;
          m_pstrb_d  = pick ? s1_apb_pstrb  : s0_apb_pstrb;
          m_pauser_d = pick ? s1_apb_pauser : s0_apb_pauser;
          m_pwuser_d = pick ? s1_apb_pwuser : s0_apb_pwuser;
          m_psel_d   = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        m_penable_d = 1'b1;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m_apb_pready) begin
          rsp_vld   = 1'b1;
          rsp_rdata = m_apb_prdata;
          rsp_err   = m_apb_pslverr;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: report a slave error with zero data; any later store pready is ignored.
          rsp_vld        = 1'b1;
          rsp_err        = 1'b1;
          stat_timeout_d = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Close the downstream transfer and hand the response to the granted port only.
    if (rsp_vld) begin
      m_psel_d    = 1'b0;
      m_penable_d = 1'b0;
      state_d     = ST_DONE;
      if (gnt_q) begin
        s1_pready_d  = 1'b1;
        s1_prdata_d  = rsp_rdata;
        s1_pslverr_d = rsp_err;
      end else begin
        s0_pready_d  = 1'b1;
        s0_prdata_d  = rsp_rdata;
        s0_pslverr_d = rsp_err;
      end
    end
  end

  // State and output registers; the pointer resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      gnt_q          <= 1'b0;
      last_q         <= 1'b1;
      cnt_q          <= '0;
      m_paddr_q      <= '0;
      m_pprot_q      <= '0;
      m_psel_q       <= 1'b0;
      m_penable_q    <= 1'b0;
      m_pwrite_q     <= 1'b0;
      m_pwdata_q     <= '0;
      m_pstrb_q      <= '0;
      m_pauser_q     <= '0;
      m_pwuser_q     <= '0;
      s0_pready_q    <= 1'b0;
      s0_prdata_q    <= '0;
      s0_pslverr_q   <= 1'b0;
      s1_pready_q    <= 1'b0;
      s1_prdata_q    <= '0;
      s1_pslverr_q   <= 1'b0;
      stat_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      m_paddr_q      <= m_paddr_d;
      m_pprot_q      <= m_pprot_d;
      m_psel_q       <= m_psel_d;
      m_penable_q    <= m_penable_d;
      m_pwrite_q     <= m_pwrite_d;
      m_pwdata_q     <= m_pwdata_d;
      m_pstrb_q      <= m_pstrb_d;
      m_pauser_q     <= m_pauser_d;
      m_pwuser_q     <= m_pwuser_d;
      s0_pready_q    <= s0_pready_d;
      s0_prdata_q    <= s0_prdata_d;
      s0_pslverr_q   <= s0_pslverr_d;
      s1_pready_q    <= s1_pready_d;
      s1_prdata_q    <= s1_prdata_d;
      s1_pslverr_q   <= s1_pslverr_d;
      stat_timeout_q <= stat_timeout_d;
    end
  end

  assign m_apb_paddr    = m_paddr_q;
  assign m_apb_pprot    = m_pprot_q;
  assign m_apb_psel     = m_psel_q;
  assign m_apb_penable  = m_penable_q;
  assign m_apb_pwrite   = m_pwrite_q;
  assign m_apb_pwdata   = m_pwdata_q;
  assign m_apb_pstrb    = m_pstrb_q;
  assign m_apb_pauser   = m_pauser_q;
  assign m_apb_pwuser   = m_pwuser_q;
  assign s0_apb_pready  = s0_pready_q;
  assign s0_apb_prdata  = s0_prdata_q;
  assign s0_apb_pslverr = s0_pslverr_q;
  assign s1_apb_pready  = s1_pready_q;
  assign s1_apb_prdata  = s1_prdata_q;
  assign s1_apb_pslverr = s1_pslverr_q;
  assign stat_timeout   = stat_timeout_q;

endmodule

// File: tb/tb_taxi_pcie_vpd_apb_arb.sv
// Bench for taxi_pcie_vpd_apb_arb: a round-robin and a fixed-priority instance share requester stimulus.
// Each instance has its own store model; outputs are sampled 1 time unit after the rising edge.
// Stimulus is a directed sequence with hand-computed expectations.
module tb_taxi_pcie_vpd_apb_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // requester stimulus, shared by both instances
  logic [15:0] s0_paddr, s1_paddr;
  logic [2:0]  s0_pprot, s1_pprot;
  logic        s0_psel, s1_psel, s0_penable, s1_penable, s0_pwrite, s1_pwrite;
  logic [31:0] s0_pwdata, s1_pwdata;
  logic [3:0]  s0_pstrb, s1_pstrb;
  logic [0:0]  s0_pauser, s1_pauser, s0_pwuser, s1_pwuser;

  // round-robin instance outputs and store
  logic        rr_s0_pready, rr_s0_pslverr, rr_s1_pready, rr_s1_pslverr;
  logic [31:0] rr_s0_prdata, rr_s1_prdata;
  logic [15:0] rr_m_paddr;
  logic [2:0]  rr_m_pprot;
  logic        rr_m_psel, rr_m_penable, rr_m_pwrite, rr_m_pready, rr_m_pslverr, rr_stat_timeout;
  logic [31:0] rr_m_pwdata, rr_m_prdata;
  logic [3:0]  rr_m_pstrb;
  logic [0:0]  rr_m_pauser, rr_m_pwuser;

  // fixed-priority instance outputs and store
  logic        fp_s0_pready, fp_s0_pslverr, fp_s1_pready, fp_s1_pslverr;
  logic [31:0] fp_s0_prdata, fp_s1_prdata;
  logic [15:0] fp_m_paddr;
  logic [2:0]  fp_m_pprot;
  logic        fp_m_psel, fp_m_penable, fp_m_pwrite, fp_m_pready, fp_m_pslverr, fp_stat_timeout;
  logic [31:0] fp_m_pwdata, fp_m_prdata;
  logic [3:0]  fp_m_pstrb;
  logic [0:0]  fp_m_pauser, fp_m_pwuser;

  // RR store: answers after store_ws wait states; store_ws < 0 never answers
  int          store_ws = 0;
  logic [31:0] store_rdata = '0;
  logic        store_err = 1'b0;
  int          acc_cnt = 0;
  always @(posedge clk) acc_cnt <= (rr_m_psel && rr_m_penable) ? acc_cnt + 1 : 0;
  assign rr_m_pready  = rr_m_psel && rr_m_penable && (store_ws >= 0) && (acc_cnt == store_ws);
  assign rr_m_prdata  = rr_m_pready ? store_rdata : 32'h0;
  assign rr_m_pslverr = rr_m_pready && store_err;

  // FP store: always zero wait states
  assign fp_m_pready  = fp_m_psel && fp_m_penable;
  assign fp_m_prdata  = fp_m_pready ? {16'h0, fp_m_paddr} : 32'h0;
  assign fp_m_pslverr = 1'b0;

  taxi_pcie_vpd_apb_arb #(.ROUND_ROBIN(1), .TIMEOUT(16)) u_rr (
    .clk(clk), .rst(rst),
    .s0_apb_paddr(s0_paddr), .s0_apb_pprot(s0_pprot), .s0_apb_psel(s0_psel), .s0_apb_penable(s0_penable),
    .s0_apb_pwrite(s0_pwrite), .s0_apb_pwdata(s0_pwdata), .s0_apb_pstrb(s0_pstrb), .s0_apb_pauser(s0_pauser),
    .s0_apb_pwuser(s0_pwuser), .s0_apb_pready(rr_s0_pready), .s0_apb_prdata(rr_s0_prdata), .s0_apb_pslverr(rr_s0_pslverr),
    .s1_apb_paddr(s1_paddr), .s1_apb_pprot(s1_pprot), .s1_apb_psel(s1_psel), .s1_apb_penable(s1_penable),
    .s1_apb_pwrite(s1_pwrite), .s1_apb_pwdata(s1_pwdata), .s1_apb_pstrb(s1_pstrb), .s1_apb_pauser(s1_pauser),
    .s1_apb_pwuser(s1_pwuser), .s1_apb_pready(rr_s1_pready), .s1_apb_prdata(rr_s1_prdata), .s1_apb_pslverr(rr_s1_pslverr),
    .m_apb_paddr(rr_m_paddr), .m_apb_pprot(rr_m_pprot), .m_apb_psel(rr_m_psel), .m_apb_penable(rr_m_penable),
    .m_apb_pwrite(rr_m_pwrite), .m_apb_pwdata(rr_m_pwdata), .m_apb_pstrb(rr_m_pstrb), .m_apb_pauser(rr_m_pauser),
    .m_apb_pwuser(rr_m_pwuser), .m_apb_pready(rr_m_pready), .m_apb_prdata(rr_m_prdata), .m_apb_pslverr(rr_m_pslverr),
    .stat_timeout(rr_stat_timeout)
  );

  taxi_pcie_vpd_apb_arb #(.ROUND_ROBIN(0), .TIMEOUT(16)) u_fp (
    .clk(clk), .rst(rst),
    .s0_apb_paddr(s0_paddr), .s0_apb_pprot(s0_pprot), .s0_apb_psel(s0_psel), .s0_apb_penable(s0_penable),
    .s0_apb_pwrite(s0_pwrite), .s0_apb_pwdata(s0_pwdata), .s0_apb_pstrb(s0_pstrb), .s0_apb_pauser(s0_pauser),
    .s0_apb_pwuser(s0_pwuser), .s0_apb_pready(fp_s0_pready), .s0_apb_prdata(fp_s0_prdata), .s0_apb_pslverr(fp_s0_pslverr),
    .s1_apb_paddr(s1_paddr), .s1_apb_pprot(s1_pprot), .s1_apb_psel(s1_psel), .s1_apb_penable(s1_penable),
    .s1_apb_pwrite(s1_pwrite), .s1_apb_pwdata(s1_pwdata), .s1_apb_pstrb(s1_pstrb), .s1_apb_pauser(s1_pauser),
    .s1_apb_pwuser(s1_pwuser), .s1_apb_pready(fp_s1_pready), .s1_apb_prdata(fp_s1_prdata), .s1_apb_pslverr(fp_s1_pslverr),
    .m_apb_paddr(fp_m_paddr), .m_apb_pprot(fp_m_pprot), .m_apb_psel(fp_m_psel), .m_apb_penable(fp_m_penable),
    .m_apb_pwrite(fp_m_pwrite), .m_apb_pwdata(fp_m_pwdata), .m_apb_pstrb(fp_m_pstrb), .m_apb_pauser(fp_m_pauser),
    .m_apb_pwuser(fp_m_pwuser), .m_apb_pready(fp_m_pready), .m_apb_prdata(fp_m_prdata), .m_apb_pslverr(fp_m_pslverr),
    .stat_timeout(fp_stat_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] req_addr(input int p, input int i);
    return (p == 0) ? 16'(256 + 4 * i) : 16'(512 + 4 * i);
  endfunction
  function automatic logic [31:0] req_wdat(input int p, input int i);
    return (p == 0) ? 32'h1000_0000 + 32'(i) : 32'h2000_0000 + 32'(i);
  endfunction
  function automatic logic [3:0] req_strb(input int p, input int i);
    return (p == 0) ? 4'(1 << i) : 4'(8 >> i);
  endfunction

  task automatic drive_req(input int p, input int i);
    if (p == 0) begin
      s0_paddr = req_addr(0, i); s0_pwdata = req_wdat(0, i); s0_pstrb = req_strb(0, i); s0_pwrite = 1'b1;
    end else begin
      s1_paddr = req_addr(1, i); s1_pwdata = req_wdat(1, i); s1_pstrb = req_strb(1, i); s1_pwrite = 1'b1;
    end
  endtask

  // Both ports issue 4 writes each, starting in the same cycle; each requester advances on its own pready.
  task automatic run_contention(input bit fp, input string tag);
    int n0, n1, k, last_p, ep, ei;
    bit bad_idle, extra;
    logic mp, me, r0, r1;
    logic [52:0] obs_m;
    n0 = 0; n1 = 0; k = 0; last_p = -1; bad_idle = 1'b0; extra = 1'b0;
    drive_req(0, 0); drive_req(1, 0);
    s0_psel = 1'b1; s1_psel = 1'b1;
    for (int c = 0; c < 100 && (n0 < 4 || n1 < 4); c++) begin
      tick();
      mp    = fp ? fp_m_psel : rr_m_psel;
      me    = fp ? fp_m_penable : rr_m_penable;
      r0    = fp ? fp_s0_pready : rr_s0_pready;
      r1    = fp ? fp_s1_pready : rr_s1_pready;
      obs_m = fp ? {fp_m_paddr, fp_m_pwdata, fp_m_pstrb, fp_m_pwrite}
                 : {rr_m_paddr, rr_m_pwdata, rr_m_pstrb, rr_m_pwrite};
      if (mp && !me) begin
        if (k >= 8) begin
          extra = 1'b1;
        end else begin
          ep = fp ? ((k >= 4) ? 1 : 0) : (k % 2);
          ei = fp ? (k % 4) : (k / 2);
          chk($sformatf("%s_grant%0d", tag, k), obs_m,
              {req_addr(ep, ei), req_wdat(ep, ei), req_strb(ep, ei), 1'b1});
          last_p = ep;
        end
        k++;
      end
      if (r0 && (r1 || last_p != 0)) bad_idle = 1'b1;
      if (r1 && (r0 || last_p != 1)) bad_idle = 1'b1;
      if (r0) begin n0++; if (n0 < 4) drive_req(0, n0); else s0_psel = 1'b0; end
      if (r1) begin n1++; if (n1 < 4) drive_req(1, n1); else s1_psel = 1'b0; end
    end
    s0_psel = 1'b0; s1_psel = 1'b0;
    chk({tag, "_grant_count"}, k, 8);
    chk({tag, "_no_extra_grant"}, extra, 0);
    chk({tag, "_idle_port_pready"}, bad_idle, 0);
    chk({tag, "_p0_done"}, n0, 4);
    chk({tag, "_p1_done"}, n1, 4);
  endtask

  initial begin
    int  rdy_at, tmo_cnt, tmo_at;
    bit  stable, seen;
    logic [31:0] rd;
    logic er;

    s0_paddr = '0; s0_pprot = '0; s0_psel = 0; s0_penable = 0; s0_pwrite = 0; s0_pwdata = '0;
    s0_pstrb = '0; s0_pauser = '0; s0_pwuser = '0;
    s1_paddr = '0; s1_pprot = '0; s1_psel = 0; s1_penable = 0; s1_pwrite = 0; s1_pwdata = '0;
    s1_pstrb = '0; s1_pauser = '0; s1_pwuser = '0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_m_psel_penable", {rr_m_psel, rr_m_penable, fp_m_psel, fp_m_penable}, 4'b0000);
    chk("rst_m_paddr_pwdata", {rr_m_paddr, rr_m_pwdata, rr_m_pstrb}, 52'h0);
    chk("rst_m_side_fields", {rr_m_pprot, rr_m_pauser, rr_m_pwuser}, 5'h0);
    chk("rst_pready", {rr_s0_pready, rr_s1_pready, fp_s0_pready, fp_s1_pready}, 4'b0000);
    chk("rst_rsp", {rr_s0_prdata, rr_s1_prdata, rr_s0_pslverr, rr_s1_pslverr}, 66'h0);
    chk("rst_stat_timeout", {rr_stat_timeout, fp_stat_timeout}, 2'b00);
    rst = 1'b0;
    tick();

    // single zero-wait read on port 0
    store_ws = 0; store_rdata = 32'hA5A5_0001; store_err = 1'b0;
    s0_paddr = 16'h0010; s0_pwrite = 1'b0; s0_pprot = 3'b101; s0_pauser = 1'b1; s0_psel = 1'b1;
    tick();
    chk("rd_setup_psel_penable", {rr_m_psel, rr_m_penable}, 2'b10);
    chk("rd_setup_paddr_pwrite", {rr_m_paddr, rr_m_pwrite}, {16'h0010, 1'b0});
    chk("rd_setup_pprot_pauser", {rr_m_pprot, rr_m_pauser}, {3'b101, 1'b1});
    chk("rd_setup_no_pready", rr_s0_pready, 0);
    tick();
    chk("rd_access_psel_penable", {rr_m_psel, rr_m_penable}, 2'b11);
    chk("rd_access_no_pready", rr_s0_pready, 0);
    tick();
    chk("rd_done_pready", {rr_s0_pready, rr_s0_pslverr, rr_s1_pready}, 3'b100);
    chk("rd_done_prdata", rr_s0_prdata, 32'hA5A5_0001);
    chk("rd_done_m_idle", {rr_m_psel, rr_m_penable}, 2'b00);
    s0_psel = 1'b0; s0_pprot = '0; s0_pauser = '0;
    tick();
    chk("rd_after_pready_low", {rr_s0_pready, rr_s0_prdata}, 33'h0);

    // 3 store wait states with a slave error
    store_ws = 3; store_err = 1'b1; store_rdata = 32'hDEAD_0005;
    s0_paddr = 16'h0020; s0_pwrite = 1'b1; s0_pwdata = 32'h5555_0005; s0_pstrb = 4'hF; s0_psel = 1'b1;
    rdy_at = -1; stable = 1'b1; rd = '0; er = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c >= 2 && c <= 5 && !(rr_m_psel && rr_m_penable)) stable = 1'b0;
      if (rr_s0_pready && rdy_at < 0) begin
        rdy_at = c; rd = rr_s0_prdata; er = rr_s0_pslverr; s0_psel = 1'b0;
      end
    end
    chk("ws_pready_cycle", rdy_at, 6);
    chk("ws_pslverr", er, 1);
    chk("ws_prdata", rd, 32'hDEAD_0005);
    chk("ws_access_stable", stable, 1);

    // store never answers: timeout abort after 16 ACCESS cycles
    store_ws = -1; store_err = 1'b0;
    s0_paddr = 16'h0030; s0_pwrite = 1'b0; s0_psel = 1'b1;
    rdy_at = -1; tmo_cnt = 0; tmo_at = -1; rd = 32'hFFFF_FFFF; er = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (rr_stat_timeout) begin tmo_cnt++; tmo_at = c; end
      if (rr_s0_pready && rdy_at < 0) begin
        rdy_at = c; rd = rr_s0_prdata; er = rr_s0_pslverr; s0_psel = 1'b0;
      end
    end
    chk("tmo_pready_cycle", rdy_at, 18);
    chk("tmo_rsp", {rd, er}, {32'h0, 1'b1});
    chk("tmo_stat_count", tmo_cnt, 1);
    chk("tmo_stat_cycle", tmo_at, 18);

    // next request (port 1 read) completes normally
    store_ws = 0; store_rdata = 32'h0000_BEEF;
    s1_paddr = 16'h0040; s1_pwrite = 1'b0; s1_psel = 1'b1;
    rdy_at = -1; seen = 1'b0; rd = '0; er = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (rr_s0_pready) seen = 1'b1;
      if (rr_s1_pready && rdy_at < 0) begin
        rdy_at = c; rd = rr_s1_prdata; er = rr_s1_pslverr; s1_psel = 1'b0;
      end
    end
    chk("post_tmo_pready_cycle", rdy_at, 3);
    chk("post_tmo_rsp", {rd, er}, {32'h0000_BEEF, 1'b0});
    chk("post_tmo_no_p0_pready", seen, 0);

    // contention, round-robin then fixed priority
    store_ws = 0; store_err = 1'b0;
    do_reset();
    run_contention(1'b0, "rr");
    do_reset();
    run_contention(1'b1, "fp");

    // reset during ACCESS of a port-1 write
    do_reset();
    store_ws = 5;
    s1_paddr = 16'h0050; s1_pwrite = 1'b1; s1_pwdata = 32'h6666_0006; s1_pstrb = 4'hF; s1_psel = 1'b1;
    tick();
    tick();
    chk("rstmid_in_access", {rr_m_psel, rr_m_penable}, 2'b11);
    rst = 1'b1;
    tick();
    chk("rstmid_m_idle", {rr_m_psel, rr_m_penable}, 2'b00);
    chk("rstmid_no_pready", {rr_s0_pready, rr_s1_pready}, 2'b00);
    rst = 1'b0; s1_psel = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rr_s0_pready || rr_s1_pready) seen = 1'b1;
    end
    chk("rstmid_no_late_pready", seen, 0);
    store_ws = 0;
    s0_paddr = 16'h0060; s0_pwrite = 1'b0; s0_psel = 1'b1;
    s1_paddr = 16'h0070; s1_pwrite = 1'b1; s1_psel = 1'b1;
    tick();
    chk("rstmid_first_tie_p0", {rr_m_psel, rr_m_paddr}, {1'b1, 16'h0060});
    s0_psel = 1'b0; s1_psel = 1'b0;
    do_reset();

    // pointer reset: after a port-0 grant a tie would go to port 1 unless reset restores the pointer
    s0_paddr = 16'h0080; s0_psel = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (rr_s0_pready) begin seen = 1'b1; s0_psel = 1'b0; end
    end
    chk("ptr_p0_transfer_done", seen, 1);
    s0_psel = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s0_paddr = 16'h0090; s1_paddr = 16'h00A0; s0_psel = 1'b1; s1_psel = 1'b1;
    tick();
    chk("ptr_reset_tie_p0", {rr_m_psel, rr_m_paddr}, {1'b1, 16'h0090});
    s0_psel = 1'b0; s1_psel = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_pcie_vpd_apb_arb.md
# taxi_pcie_vpd_apb_arb

Two-port APB arbiter that shares one VPD backing store (BRAM, EEPROM bridge, etc.) between the PCIe VPD capability's APB master and a management-side APB master. Sits between the capability's `m_apb` and the storage, with a second upstream port for firmware or host-management access. Transfers are fully serialized, with round-robin or fixed priority. A per-transfer timeout guarantees that a hung store cannot stall VPD config accesses indefinitely.

## Interface

**Parameters**

- `ROUND_ROBIN`, default 1: 1 selects round-robin; 0 selects fixed priority with port 0 always winning.
- `TIMEOUT`, default 1024: maximum ACCESS-phase cycles before the transfer is aborted; 0 disables the timeout.

**Ports**

- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `s0_apb`, `taxi_apb_if.slv`: port 0, normally connected to the VPD capability.
- `s1_apb`, `taxi_apb_if.slv`: port 1, normally connected to the management master.
- `m_apb`, `taxi_apb_if.mst`: downstream port to the VPD store.
- `stat_timeout`, output, 1: one-cycle pulse when a transfer is aborted by timeout.

**Elaboration checks**

- `DATA_W` and `ADDR_W` must match across all three interfaces; otherwise `$fatal`.
- `pstrb`, `pprot`, `pauser` and `pwuser` widths follow the interfaces.

## Operation

**States**

- IDLE: evaluate requests. A port requests when its `psel=1`, in either phase.
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both request:
    - `ROUND_ROBIN=1`: grant the port not granted last. The last-granted pointer resets to 1, so port 0 wins the first tie.
    - `ROUND_ROBIN=0`: grant port 0.
  - On grant:
    - Latch the granted port's `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot`, `pauser` and `pwuser` into the `m_apb` output registers.
    - Update the pointer and go to SETUP.
- SETUP: `m_apb.psel=1`, `penable=0`. Next state is ACCESS.
- ACCESS: `m_apb.psel=1`, `penable=1`. The timeout counter increments each cycle.
  - On `m_apb.pready=1`:
    - Capture `prdata` and `pslverr` into the granted port's response registers.
    - Go to DONE.
  - If `TIMEOUT!=0` and the counter reaches `TIMEOUT-1` without `pready`:
    - Load the response with `prdata=0` and `pslverr=1`.
    - Pulse `stat_timeout` in the DONE cycle.
    - Go to DONE.
    - A late `pready` from the store is ignored.
- DONE:
  - `m_apb.psel=0`, `penable=0`.
  - The granted port has `pready=1` for exactly this cycle, with registered `prdata`/`pslverr` valid.
  - The timeout counter clears. Next state is IDLE.
  - Port `psel` is not sampled in DONE. This lets the requester drop `psel` or begin a new SETUP before the next arbitration.

**Always true**

- The non-granted port has `pready=0` at all times.
- Its request stays pending; it is never dropped.
- `prdata` and `pslverr` on any port are 0 whenever that port's `pready=0`.

**Reset values**

- `m_apb.psel`, `m_apb.penable`: 0.
- `m_apb.paddr`, `m_apb.pwdata`, `m_apb.pstrb`, `m_apb.pprot`, `m_apb.pauser`, `m_apb.pwuser`: 0.
- `s0_apb.pready`, `s1_apb.pready`: 0.
- `s0_apb.prdata`, `s1_apb.prdata`: 0.
- `s0_apb.pslverr`, `s1_apb.pslverr`: 0.
- `stat_timeout`: 0.
- State is IDLE and the last-granted pointer is 1.

**Reset mid-transfer**

- Outputs return to their reset values on the next edge.
- No `pready` is issued for the aborted transfer.

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- Minimum transfer, with the store returning `pready` in the first ACCESS cycle:
  - Request seen in IDLE at cycle T.
  - `m_apb.psel` rises at T+1 (SETUP).
  - `penable` rises at T+2 (ACCESS).
  - Requester `pready` is asserted at T+3 (DONE).
  - Back to IDLE at T+4.
- Back-to-back throughput is 4 cycles per transfer.
- Each downstream wait state adds 1 cycle.
- Under continuous contention with `ROUND_ROBIN=1`, grants alternate 0,1,0,1.
- Timeout abort: `pready` to the requester arrives `TIMEOUT+2` cycles after the grant cycle.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide, saturates, and never wraps within one transfer.

## Test plan

1. Single read on port 0 at addr `0x0010`, store returns `0xA5A5_0001` with zero wait states.
   - Required: `s0_apb.pready` goes high 3 cycles after `psel`, with `prdata=0xA5A5_0001` and `pslverr=0`.
   - Required: `m_apb.paddr=0x0010` and `pwrite=0`.
2. Both ports request writes in the same cycle, 4 transfers each, `ROUND_ROBIN=1`.
   - Required: `m_apb` order is p0,p1,p0,p1,...
   - Required: `pwdata` and `pstrb` match the originating port, and there is no `pready` to the idle port.
3. Same stimulus as scenario 2 with `ROUND_ROBIN=0`, and port 0 keeps a request pending.
   - Required: all 4 port-0 transfers complete before port 1 is granted.
4. Store never asserts `pready`, with `TIMEOUT=16`.
   - Required: the requester gets `pready=1`, `pslverr=1` and `prdata=0` 18 cycles after the grant cycle.
   - Required: `stat_timeout` pulses once, and the next request proceeds normally.
5. Store inserts 3 wait states and returns `pslverr=1`.
   - Required: requester `pready` arrives at T+6 with `pslverr=1`.
   - Required: `m_apb.psel` and `penable` stay stable throughout ACCESS.
6. `rst` is asserted during ACCESS of a port-1 write.
   - Required: `m_apb.psel=0` next cycle, and no `pready` on either port.
   - Required: the first post-reset tie is granted to port 0.
